// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 register file and its clear sequencer.
package rv_pkg;

  localparam int         RV_XLEN  = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Walks the register array writing zero to one entry per cycle after reset or
// on request; busy stays high for the whole walk.
module regfile_clear_fsm
  import rv_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr_req,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr,
  output logic          o_busy
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_e     r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_busy;

  // A clear request during the walk is ignored; only reset restarts it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= RF_CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          if (r_clr_cnt == LAST) begin
            r_state   <= RF_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          if (i_clr_req) begin
            r_state   <= RF_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_clr_we   = (r_state == RF_CLEAR);
  assign o_clr_addr = r_clr_cnt;
  assign o_busy     = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with sequential hardware clear,
// optional write-to-read bypass and per-register pending bits.
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN    = RV_XLEN,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]    o_rd_pend,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic              i_pend_set,
  input  logic [AW-1:0]     i_pend_addr,
  input  logic              i_clr_req,
  output logic              o_busy
);

  logic            w_busy;
  logic            w_clr_we;
  logic [AW-1:0]   w_clr_addr;
  logic            w_usr_we;
  logic            w_usr_pend;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;

  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] r_pend;

  regfile_clear_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_fsm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr_req  (i_clr_req),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_busy     (w_busy)
  );

  assign w_usr_we   = !w_busy && i_wr_en    && ((i_wr_addr   != '0) || !ZERO_R0);
  assign w_usr_pend = !w_busy && i_pend_set && ((i_pend_addr != '0) || !ZERO_R0);

  // The clear walk owns the single write port while busy.
  assign w_we    = w_clr_we || w_usr_we;
  assign w_waddr = w_clr_we ? w_clr_addr : i_wr_addr;
  assign w_wdata = w_clr_we ? '0 : i_wr_data;

  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Set is assigned after clear so a newer producer wins on the same register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend <= '0;
    end else if (w_busy || i_clr_req) begin
      r_pend <= '0;
    end else begin
      if (w_usr_we)   r_pend[i_wr_addr]   <= 1'b0;
      if (w_usr_pend) r_pend[i_pend_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rdata;

    assign w_ra = i_rd_addr[p*AW +: AW];

    always_comb begin
      w_rdata = r_mem[w_ra];
      if (w_busy)
        w_rdata = '0;
      else if (ZERO_R0 && (w_ra == '0))
        w_rdata = '0;
      else if (BYPASS && w_usr_we && (i_wr_addr == w_ra))
        w_rdata = i_wr_data;
    end

    assign o_rd_data[p*XLEN +: XLEN] = w_rdata;
    assign o_rd_pend[p]              = !w_busy && r_pend[w_ra];
  end

  assign o_busy = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing and a non-bypassing register file driven in lockstep.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_pend, rd_pend_nb;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        clr_req;
  logic        busy, busy_nb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_pend(rd_pend), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_pend_set(pend_set), .i_pend_addr(pend_addr), .i_clr_req(clr_req), .o_busy(busy)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr), .o_rd_data(rd_data_nb),
    .o_rd_pend(rd_pend_nb), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_pend_set(pend_set), .i_pend_addr(pend_addr), .i_clr_req(clr_req), .o_busy(busy_nb)
  );

  task automatic count_busy(output int n, output bit bad);
    n = 0; bad = 0;
    while (busy && n < 100) begin
      #1;
      if (rd_data !== 64'd0 || rd_pend !== 2'b00 || rd_data_nb !== 64'd0) bad = 1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int n; bit bad; int zbad;
    rd_addr = {5'd7, 5'd5};
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    n_chk++; if (rd_data !== 64'd0 || rd_pend !== 2'b00) begin n_fail++;
      $display("FAIL reset_outputs data %h pend %b want 0", rd_data, rd_pend); end
    reset = 1'b0;
    count_busy(n, bad);
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL reset_busy_len got %0d want 32", n); end
    n_chk++; if (bad) begin n_fail++; $display("FAIL reset_read_during_clear got nonzero want 0"); end
    n_chk++; if (busy_nb !== 1'b0) begin n_fail++; $display("FAIL reset_busy_nb got %b want 0", busy_nb); end
    zbad = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      if (rd_data !== 64'd0 || rd_data_nb !== 64'd0) zbad++;
    end
    n_chk++; if (zbad != 0) begin n_fail++; $display("FAIL reset_all_zero got %0d nonzero want 0", zbad); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd5, 5'd5};
    #1;
    n_chk++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL bypass_same_cycle got %h want deadbeef", rd_data[31:0]); end
    n_chk++; if (rd_data_nb[31:0] !== 32'h0) begin n_fail++;
      $display("FAIL nobypass_same_cycle got %h want 0", rd_data_nb[31:0]); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_chk++; if (rd_data_nb !== {2{32'hDEAD_BEEF}}) begin n_fail++;
      $display("FAIL nobypass_next_cycle got %h want deadbeef x2", rd_data_nb); end
    n_chk++; if (rd_data !== {2{32'hDEAD_BEEF}}) begin n_fail++;
      $display("FAIL bypass_next_cycle got %h want deadbeef x2", rd_data); end
  endtask

  task automatic test_zero;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    #1;
    n_chk++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", rd_data); end
    @(negedge clk);
    wr_en = 1'b0; pend_set = 1'b1; pend_addr = 5'd0;
    #1;
    n_chk++; if (rd_data !== 64'd0 || rd_data_nb !== 64'd0) begin n_fail++;
      $display("FAIL x0_stored got %h/%h want 0", rd_data, rd_data_nb); end
    @(negedge clk);
    pend_set = 1'b0;
    #1;
    n_chk++; if (rd_pend !== 2'b00) begin n_fail++; $display("FAIL x0_pend got %b want 00", rd_pend); end
  endtask

  task automatic test_pend;
    @(negedge clk);
    pend_set = 1'b1; pend_addr = 5'd7; rd_addr = {5'd7, 5'd7};
    #1;
    n_chk++; if (rd_pend !== 2'b00) begin n_fail++; $display("FAIL pend_no_bypass got %b want 00", rd_pend); end
    @(negedge clk);
    pend_set = 1'b0;
    #1;
    n_chk++; if (rd_pend !== 2'b11) begin n_fail++; $display("FAIL pend_set got %b want 11", rd_pend); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
    #1;
    n_chk++; if (rd_pend !== 2'b11 || rd_data[31:0] !== 32'd42) begin n_fail++;
      $display("FAIL pend_wb_same_cycle pend %b data %0d want 11 42", rd_pend, rd_data[31:0]); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_chk++; if (rd_pend !== 2'b00) begin n_fail++; $display("FAIL pend_cleared got %b want 00", rd_pend); end
    n_chk++; if (rd_data !== {32'd42, 32'd42}) begin n_fail++; $display("FAIL pend_wb_data got %h want 42 x2", rd_data); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd99; pend_set = 1'b1; pend_addr = 5'd7;
    @(negedge clk);
    wr_en = 1'b0; pend_set = 1'b0;
    #1;
    n_chk++; if (rd_pend !== 2'b11 || rd_data_nb[31:0] !== 32'd99) begin n_fail++;
      $display("FAIL pend_set_wins pend %b data %0d want 11 99", rd_pend, rd_data_nb[31:0]); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hA5A5_0001;
    @(negedge clk);
    wr_addr = 5'd11; wr_data = 32'h5A5A_0002; rd_addr = {5'd11, 5'd10};
    #1;
    n_chk++; if (rd_data !== {32'h5A5A_0002, 32'hA5A5_0001}) begin n_fail++;
      $display("FAIL b2b_bypass got %h want 5a5a0002a5a50001", rd_data); end
    n_chk++; if (rd_data_nb !== {32'h0, 32'hA5A5_0001}) begin n_fail++;
      $display("FAIL b2b_nobypass got %h want 00000000a5a50001", rd_data_nb); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_chk++; if (rd_data_nb !== {32'h5A5A_0002, 32'hA5A5_0001}) begin n_fail++;
      $display("FAIL b2b_stored got %h want 5a5a0002a5a50001", rd_data_nb); end
  endtask

  task automatic test_clear;
    int n; bit bad; int zbad;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
    end
    @(negedge clk);
    wr_en = 1'b0; pend_set = 1'b1; pend_addr = 5'd9; rd_addr = {5'd31, 5'd3};
    #1;
    n_chk++; if (rd_data !== {32'd31, 32'd3}) begin n_fail++; $display("FAIL fill_data got %h want 31/3", rd_data); end
    @(negedge clk);
    pend_set = 1'b0; rd_addr = {5'd9, 5'd3};
    #1;
    n_chk++; if (rd_pend !== 2'b10) begin n_fail++; $display("FAIL fill_pend got %b want 10", rd_pend); end
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF_FFFF;
      pend_set = 1'b1; pend_addr = 5'd6; rd_addr = {5'd6, 5'd4};
      clr_req = (n == 20);
      #1;
      if (rd_data !== 64'd0 || rd_pend !== 2'b00) bad = 1;
      @(negedge clk);
      n++;
    end
    wr_en = 1'b0; pend_set = 1'b0; clr_req = 1'b0;
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL clear_busy_len got %0d want 32", n); end
    n_chk++; if (bad) begin n_fail++; $display("FAIL clear_read_during got nonzero want 0"); end
    zbad = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      if (rd_data !== 64'd0 || rd_data_nb !== 64'd0 || rd_pend !== 2'b00) zbad++;
    end
    n_chk++; if (zbad != 0) begin n_fail++; $display("FAIL clear_all_zero got %0d nonzero want 0", zbad); end
  endtask

  task automatic test_reset_mid;
    int n; bit bad;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd77;
    @(negedge clk);
    wr_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy got %b want 1", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    count_busy(n, bad);
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL midreset_busy_len got %0d want 32", n); end
    rd_addr = {5'd3, 5'd3};
    #1;
    n_chk++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL midreset_x3 got %h want 0", rd_data); end
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0; clr_req = 1'b0;
    test_reset;
    test_bypass;
    test_zero;
    test_pend;
    test_back_to_back;
    test_clear;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
